// File: rtl/da_pkg.sv
// Shared definitions for the DAC request arbiter: defaults, FSM encodings and
// the round-robin index helper.
package da_pkg;

  localparam int DA_DW       = 10;
  localparam int DA_NREQ_DEF = 4;
  localparam int DA_GAP_DEF  = 50;
  localparam int DA_TO_DEF   = 1023;
  localparam int DA_LO_MAX   = 4;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_GRANT   = 6'b000010,
    ST_START   = 6'b000100,
    ST_WAIT_LO = 6'b001000,
    ST_WAIT_HI = 6'b010000,
    ST_GAP     = 6'b100000
  } da_state_e;

  // Index i folded back into 0..n-1; callers never pass i >= 2n.
  function automatic int da_rr_wrap(input int i, input int n);
    return (i >= n) ? i - n : i;
  endfunction

endpackage

// File: rtl/da_arbiter_if.sv
// Requester-side and DAC-engine-side signals of the arbiter. The slave modport
// is the arbiter; the master modport is the user logic plus the DAC engine.
interface da_arbiter_if
  import da_pkg::*;
#(
  parameter int N_REQ = DA_NREQ_DEF,
  parameter int DW    = DA_DW
);
  logic [N_REQ-1:0]    REQ;
  logic [N_REQ*DW-1:0] REQ_DATA;
  logic [N_REQ-1:0]    GNT;
  logic [N_REQ-1:0]    DONE;
  logic                BUSY;
  logic                ERR_TO;
  logic [DW-1:0]       DA_DATA;
  logic                DA_SEND_START;
  logic                DA_SEND_FINISH;

  modport master (
    output REQ, REQ_DATA, DA_SEND_FINISH,
    input  GNT, DONE, BUSY, ERR_TO, DA_DATA, DA_SEND_START
  );

  modport slave (
    input  REQ, REQ_DATA, DA_SEND_FINISH,
    output GNT, DONE, BUSY, ERR_TO, DA_DATA, DA_SEND_START
  );
endinterface

// File: rtl/da_rr_pick.sv
// Combinational round-robin select: first asserted request at or after ptr,
// wrapping past N_REQ-1 back to 0.
module da_rr_pick
  import da_pkg::*;
#(
  parameter int N_REQ = DA_NREQ_DEF,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    idx,
  output logic             valid
);

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[PW'(da_rr_wrap(int'(ptr) + k, N_REQ))]) begin
        gnt = '0;
        gnt[PW'(da_rr_wrap(int'(ptr) + k, N_REQ))] = 1'b1;
        idx   = PW'(da_rr_wrap(int'(ptr) + k, N_REQ));
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/da_arbiter.sv
// Shares one TLC5615 serial engine between N_REQ requesters: round-robin grant,
// start pulse, finish tracking with timeouts, and a minimum inter-conversion gap.
module da_arbiter
  import da_pkg::*;
#(
  parameter int N_REQ   = DA_NREQ_DEF,
  parameter int DW      = DA_DW,
  parameter int GAP_CYC = DA_GAP_DEF,
  parameter int TO_CYC  = DA_TO_DEF
) (
  input logic         CLK_50M,
  input logic         RST_N,
  da_arbiter_if.slave bus
);

  localparam int PW     = $clog2(N_REQ);
  localparam int TO_CW  = $clog2(TO_CYC + 2);
  localparam int GAP_CW = $clog2(GAP_CYC + 1);

  da_state_e          state_reg;
  logic [N_REQ-1:0]   gnt_reg;
  logic [N_REQ-1:0]   done_reg;
  logic               err_reg;
  logic [DW-1:0]      data_reg;
  logic               start_reg;
  logic [PW-1:0]      rr_ptr_reg;
  logic [PW-1:0]      cur_reg;
  logic [TO_CW-1:0]   to_cnt_reg;
  logic [GAP_CW-1:0]  gap_cnt_reg;

  logic [DW-1:0]      code_arr [N_REQ];
  logic [N_REQ-1:0]   pick_gnt;
  logic [PW-1:0]      pick_idx;
  logic               pick_valid;
  logic               gap_done;
  logic               take_grant;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_code
      assign code_arr[gi] = bus.REQ_DATA[gi*DW +: DW];
    end
  endgenerate

  da_rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req   (bus.REQ),
    .ptr   (rr_ptr_reg),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign gap_done   = (state_reg == ST_GAP) && (gap_cnt_reg == GAP_CW'(GAP_CYC - 1));
  // Requests are sampled on the way into GRANT, so GNT is visible during GRANT.
  assign take_grant = ((state_reg == ST_IDLE) || gap_done) && pick_valid && bus.DA_SEND_FINISH;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_reg   <= ST_IDLE;
      gnt_reg     <= '0;
      done_reg    <= '0;
      err_reg     <= 1'b0;
      data_reg    <= '0;
      start_reg   <= 1'b0;
      rr_ptr_reg  <= '0;
      cur_reg     <= '0;
      to_cnt_reg  <= '0;
      gap_cnt_reg <= '0;
    end else begin
      gnt_reg     <= '0;
      done_reg    <= '0;
      start_reg   <= 1'b0;
      // Counters restart on every state entry; only dwelling states advance them.
      to_cnt_reg  <= '0;
      gap_cnt_reg <= '0;

      unique case (state_reg)
        ST_IDLE: ;
        ST_GRANT: begin
          state_reg <= ST_START;
          start_reg <= 1'b1;
        end
        ST_START: state_reg <= ST_WAIT_LO;
        ST_WAIT_LO: begin
          if (!bus.DA_SEND_FINISH) begin
            state_reg <= ST_WAIT_HI;
          end else if (to_cnt_reg == TO_CW'(DA_LO_MAX - 1)) begin
            err_reg   <= 1'b1;
            state_reg <= ST_GAP;
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_CW'(1);
          end
        end
        ST_WAIT_HI: begin
          if (bus.DA_SEND_FINISH) begin
            done_reg  <= N_REQ'(1) << cur_reg;
            state_reg <= ST_GAP;
          end else if (to_cnt_reg > TO_CW'(TO_CYC)) begin
            err_reg   <= 1'b1;
            state_reg <= ST_GAP;
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_CW'(1);
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            state_reg <= ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_CW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (take_grant) begin
        state_reg  <= ST_GRANT;
        gnt_reg    <= pick_gnt;
        data_reg   <= code_arr[pick_idx];
        cur_reg    <= pick_idx;
        rr_ptr_reg <= PW'(da_rr_wrap(int'(pick_idx) + 1, N_REQ));
      end
    end
  end

  assign bus.GNT           = gnt_reg;
  assign bus.DONE          = done_reg;
  assign bus.BUSY          = (state_reg != ST_IDLE);
  assign bus.ERR_TO        = err_reg;
  assign bus.DA_DATA       = data_reg;
  assign bus.DA_SEND_START = start_reg;

endmodule
